// File: rtl/demux_1to4_stream_pkg.sv
// Shared constants, slot state type and select decoder for the 1-to-4 stream demux.
// Imported by the interface, the output slot and the top.
package demux_1to4_stream_pkg;

   localparam int N_OUT = 4;
   localparam int SEL_W = 2;

   localparam logic [SEL_W-1:0] CH_A = 2'd0;
   localparam logic [SEL_W-1:0] CH_B = 2'd1;
   localparam logic [SEL_W-1:0] CH_C = 2'd2;
   localparam logic [SEL_W-1:0] CH_D = 2'd3;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      logic [N_OUT-1:0] oh;
      oh = 4'b0000;
      case (sel)
         CH_A:    oh = 4'b0001;
         CH_B:    oh = 4'b0010;
         CH_C:    oh = 4'b0100;
         CH_D:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/demux_1to4_stream_if.sv
// Stream bundle between the upstream/downstream side (master) and the demux (slave).
// Carries the single input stream, the four output lanes and the per-lane counters.
interface demux_1to4_stream_if
   import demux_1to4_stream_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);

   logic [WIDTH-1:0]       in_data;
   logic [SEL_W-1:0]       in_sel;
   logic                   in_valid;
   logic                   in_ready;
   logic [N_OUT*WIDTH-1:0] out_data;
   logic [N_OUT-1:0]       out_valid;
   logic [N_OUT-1:0]       out_ready;
   logic [N_OUT*CNT_W-1:0] xfer_cnt;

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid, xfer_cnt
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_valid, xfer_cnt
   );

endinterface

// File: rtl/demux_out_slot.sv
// One output lane: a single-entry holding register with EMPTY/FULL state and
// a wrapping count of words loaded into it.
module demux_out_slot
   import demux_1to4_stream_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic [CNT_W-1:0] cnt_o
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // state, held word and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_EMPTY;
         data_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // a load while FULL is only offered when the held word leaves this cycle (pass-through)
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         SLOT_EMPTY: begin
            if (load_i) begin
               state_d = SLOT_FULL;
            end else begin
               state_d = SLOT_EMPTY;
            end
         end
         SLOT_FULL: begin
            if (load_i) begin
               state_d = SLOT_FULL;
            end else if (out_ready_i) begin
               state_d = SLOT_EMPTY;
            end else begin
               state_d = SLOT_FULL;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
      if (load_i) begin
         data_d = data_i;
         cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         data_d = data_q;
         cnt_d  = cnt_q;
      end
   end

   assign out_valid_o = (state_q == SLOT_FULL);
   assign out_data_o  = data_q;
   assign cnt_o       = cnt_q;

endmodule

// File: rtl/demux_1to4_stream.sv
// 1-to-4 stream demultiplexer: routes each accepted word to the lane named by in_sel.
// Backpressure comes only from the selected lane; outputs are all registered in the slots.
module demux_1to4_stream
   import demux_1to4_stream_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   demux_1to4_stream_if.slave  stream_io
);

   logic [N_OUT-1:0]       valid_s;
   logic [N_OUT*WIDTH-1:0] data_s;
   logic [N_OUT*CNT_W-1:0] cnt_s;
   logic [N_OUT-1:0]       sel_oh_s;
   logic [N_OUT-1:0]       load_s;
   logic                   in_ready_s;
   logic                   in_xfer_s;

   assign sel_oh_s = sel_onehot(stream_io.in_sel);

   // ready looks only at the selected lane, never at in_valid
   always_comb begin
      in_ready_s = 1'b1;
      if (|(sel_oh_s & valid_s & ~stream_io.out_ready)) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = 1'b1;
      end
   end

   assign in_xfer_s = stream_io.in_valid & in_ready_s;

   // steer the accepted word to exactly one slot
   always_comb begin
      load_s = {N_OUT{1'b0}};
      if (in_xfer_s) begin
         load_s = sel_oh_s;
      end else begin
         load_s = {N_OUT{1'b0}};
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      demux_out_slot #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .load_i      (load_s[k]),
         .data_i      (stream_io.in_data),
         .out_ready_i (stream_io.out_ready[k]),
         .out_valid_o (valid_s[k]),
         .out_data_o  (data_s[k*WIDTH +: WIDTH]),
         .cnt_o       (cnt_s[k*CNT_W +: CNT_W])
      );
   end

   assign stream_io.in_ready  = in_ready_s;
   assign stream_io.out_valid = valid_s;
   assign stream_io.out_data  = data_s;
   assign stream_io.xfer_cnt  = cnt_s;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: directed table, corner sequences and random
// traffic compared against a per-lane queue model with modular counters.
module tb_demux_1to4_stream;
   import demux_1to4_stream_pkg::*;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   typedef logic [WIDTH-1:0] word_t;

   typedef struct {
      logic        v;
      logic [1:0]  s;
      logic [3:0]  d;
      logic [3:0]  r;
      logic        exp_rdy;
      logic [3:0]  exp_valid;
      logic [15:0] exp_data;
      logic [31:0] exp_cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux_1to4_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   demux_1to4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .stream_io (bus)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   word_t mq [N_OUT][$];
   int    mcnt [N_OUT];
   vec_t  tbl [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_OUT; k++) begin
         mq[k].delete();
         mcnt[k] = 0;
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < N_OUT; k++) begin
         chk($sformatf("out_valid[%0d]", k), 64'(bus.out_valid[k]), 64'(mq[k].size() > 0));
         if (mq[k].size() > 0)
            chk($sformatf("out_data[%0d]", k), 64'(bus.out_data[k*WIDTH +: WIDTH]), 64'(mq[k][0]));
         chk($sformatf("xfer_cnt[%0d]", k), 64'(bus.xfer_cnt[k*CNT_W +: CNT_W]), 64'(mcnt[k]));
      end
   endtask

   // One clock: drive at negedge, check ready, advance the model at posedge, check outputs.
   task automatic cycle(input logic v, input logic [1:0] s, input logic [3:0] d,
                        input logic [3:0] r, output logic rdy_o);
      logic exp_rdy;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_sel    = s;
      bus.in_data   = d;
      bus.out_ready = r;
      #1;
      exp_rdy = (mq[s].size() == 0) || r[s];
      rdy_o   = bus.in_ready;
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      @(posedge clk);
      for (int k = 0; k < N_OUT; k++) begin
         if (r[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      end
      if (v && exp_rdy) begin
         mq[s].push_back(d);
         mcnt[s] = (mcnt[s] + 1) % (1 << CNT_W);
      end
      #1;
      check_model();
   endtask

   initial begin
      logic rdy;
      bus.in_valid  = 1'b0;
      bus.in_sel    = 2'd0;
      bus.in_data   = 4'h0;
      bus.out_ready = 4'h0;
      model_reset();

      tbl[0] = '{1'b1, 2'd0, 4'h1, 4'hF, 1'b1, 4'b0001, 16'h0001, 32'h0000_0001};
      tbl[1] = '{1'b1, 2'd1, 4'h2, 4'hF, 1'b1, 4'b0010, 16'h0020, 32'h0000_0101};
      tbl[2] = '{1'b1, 2'd2, 4'h3, 4'hF, 1'b1, 4'b0100, 16'h0300, 32'h0001_0101};
      tbl[3] = '{1'b1, 2'd3, 4'h4, 4'hF, 1'b1, 4'b1000, 16'h4000, 32'h0101_0101};
      tbl[4] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 16'h0000, 32'h0101_0101};

      // reset state
      #13;
      chk("rst out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst out_data", 64'(bus.out_data), 64'h0);
      chk("rst xfer_cnt", 64'(bus.xfer_cnt), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // one word per lane, each drained the cycle after it appears
      for (int i = 0; i < 5; i++) begin
         cycle(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r, rdy);
         chk($sformatf("tbl%0d in_ready", i), 64'(rdy), 64'(tbl[i].exp_rdy));
         chk($sformatf("tbl%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_valid));
         for (int k = 0; k < N_OUT; k++) begin
            if (tbl[i].exp_valid[k])
               chk($sformatf("tbl%0d out_data[%0d]", i, k),
                   64'(bus.out_data[k*WIDTH +: WIDTH]), 64'(tbl[i].exp_data[k*4 +: 4]));
         end
         chk($sformatf("tbl%0d xfer_cnt", i), 64'(bus.xfer_cnt), 64'(tbl[i].exp_cnt));
      end

      // lane 2 stalled: second word waits, then both leave in order
      cycle(1'b1, 2'd2, 4'h5, 4'b1011, rdy);
      chk("stall first accept", 64'(rdy), 64'h1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 2'd2, 4'h6, 4'b1011, rdy);
         chk("stall in_ready", 64'(rdy), 64'h0);
         chk("stall held data", 64'(bus.out_data[2*WIDTH +: WIDTH]), 64'h5);
      end
      cycle(1'b1, 2'd2, 4'h6, 4'hF, rdy);
      chk("stall pass-through data", 64'(bus.out_data[2*WIDTH +: WIDTH]), 64'h6);
      cycle(1'b0, 2'd2, 4'h0, 4'hF, rdy);
      chk("stall lane2 count", 64'(bus.xfer_cnt[2*CNT_W +: CNT_W]), 64'h3);

      // lane 1 stuck full must not slow lanes 0 and 3
      cycle(1'b1, 2'd1, 4'h7, 4'b1101, rdy);
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, 4'(i + 8), 4'b1101, rdy);
         chk("indep in_ready", 64'(rdy), 64'h1);
      end
      cycle(1'b0, 2'd0, 4'h0, 4'hF, rdy);

      // asynchronous reset between edges with every lane full
      for (int k = 0; k < N_OUT; k++) cycle(1'b1, 2'(k), 4'(k + 8), 4'h0, rdy);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async rst out_valid", 64'(bus.out_valid), 64'h0);
      chk("async rst out_data", 64'(bus.out_data), 64'h0);
      chk("async rst xfer_cnt", 64'(bus.xfer_cnt), 64'h0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      cycle(1'b0, 2'd0, 4'h0, 4'hF, rdy);
      chk("no stale after rst", 64'(bus.out_valid), 64'h0);

      // continuous pass-through stream on lane 3; 256 words wrap the counter
      for (int i = 0; i < 256; i++) begin
         cycle(1'b1, 2'd3, 4'(i), 4'hF, rdy);
         chk("stream in_ready", 64'(rdy), 64'h1);
         if (i == 254) chk("stream cnt 255", 64'(bus.xfer_cnt[3*CNT_W +: CNT_W]), 64'hFF);
      end
      chk("stream cnt wrap", 64'(bus.xfer_cnt[3*CNT_W +: CNT_W]), 64'h0);
      cycle(1'b0, 2'd3, 4'h0, 4'hF, rdy);

      // data toggling against a stalled lane must change nothing
      cycle(1'b1, 2'd0, 4'h9, 4'b1110, rdy);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 2'd0, 4'($urandom), 4'b1110, rdy);
         chk("toggle in_ready", 64'(rdy), 64'h0);
         chk("toggle held data", 64'(bus.out_data[0 +: WIDTH]), 64'h9);
      end

      // random traffic against the queue model
      for (int i = 0; i < 1500; i++) begin
         cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
               4'($urandom), rdy);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 4'h0, 4'hF, rdy);
      chk("final drained", 64'(bus.out_valid), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
